// File: rtl/dtc_preimage_search_if.sv
// ---------------------------------------------------------------------------
// dtc_preimage_search_if
// Purpose : bundles the request, classifier and result signals of the
//           preimage search engine.
// Signals : start/mode/target/abort  - search request and termination
//           cand_out / cls_in        - candidate to classifier, class back
//           busy/done                - search status
//           found/match_vec/match_count/aborted - results of last search
// Modports: master - requester + classifier side
//           slave  - search engine side
// ---------------------------------------------------------------------------
interface dtc_preimage_search_if;
    logic        start;
    logic        mode;
    logic [2:0]  target;
    logic        abort;
    logic [9:0]  cand_out;
    logic [2:0]  cls_in;
    logic        busy;
    logic        done;
    logic        found;
    logic [9:0]  match_vec;
    logic [10:0] match_count;
    logic        aborted;

    modport master (
        output start, mode, target, abort, cls_in,
        input  cand_out, busy, done, found, match_vec, match_count, aborted
    );

    modport slave (
        input  start, mode, target, abort, cls_in,
        output cand_out, busy, done, found, match_vec, match_count, aborted
    );
endinterface

// File: rtl/dtc_preimage_search.sv
// ---------------------------------------------------------------------------
// dtc_preimage_search
// Purpose : walks every 10-bit feature vector through an external
//           combinational classifier and records which vectors map to a
//           requested class (stop at first hit, or count all hits).
// Ports   : clk  - single clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - dtc_preimage_search_if.slave (request, classifier
//                  handshake, status and results)
// ---------------------------------------------------------------------------
module dtc_preimage_search (
    input  logic                    clk,
    input  logic                    rst,
    dtc_preimage_search_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [9:0]  r_cand;
    logic [2:0]  r_target_q;
    logic        r_mode_q;
    logic        r_found;
    logic [9:0]  r_match_vec;
    logic [10:0] r_match_count;
    logic        r_aborted;

    logic        w_hit;
    logic        w_last_cand;
    logic        w_stop_first;

    assign w_hit        = (bus.cls_in == r_target_q);
    assign w_last_cand  = (r_cand == 10'd1023);
    // Find-first mode leaves the scan on the hit itself.
    assign w_stop_first = w_hit && !r_mode_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort takes precedence over a hit in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (bus.abort || w_stop_first || w_last_cand) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Candidate counter, captured parameters and results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand        <= '0;
            r_target_q    <= '0;
            r_mode_q      <= 1'b0;
            r_found       <= 1'b0;
            r_match_vec   <= '0;
            r_match_count <= '0;
            r_aborted     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cand        <= '0;
                        r_target_q    <= bus.target;
                        r_mode_q      <= bus.mode;
                        r_found       <= 1'b0;
                        r_match_vec   <= '0;
                        r_match_count <= '0;
                        r_aborted     <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (bus.abort) begin
                        // The candidate on the bus during abort is not scored.
                        r_aborted <= 1'b1;
                    end else begin
                        if (w_hit) begin
                            r_match_count <= r_match_count + 11'd1;
                            if (!r_found) begin
                                r_found     <= 1'b1;
                                r_match_vec <= r_cand;
                            end
                        end
                        // Hold on a find-first hit and on the last vector so
                        // cand_out never wraps within a search.
                        if (!w_stop_first && !w_last_cand) begin
                            r_cand <= r_cand + 10'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cand_out    = r_cand;
    assign bus.busy        = (r_state == S_SCAN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.found       = r_found;
    assign bus.match_vec   = r_match_vec;
    assign bus.match_count = r_match_count;
    assign bus.aborted     = r_aborted;

endmodule

// File: tb/tb_dtc_preimage_search.sv
`timescale 1ns/1ps
module tb_dtc_preimage_search;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dtc_preimage_search_if bus ();

    dtc_preimage_search dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint      t_edge;
        int          cyc;
        logic        found;
        logic [9:0]  vec;
        logic [10:0] cnt;
        logic        ab;
    } exp_t;

    exp_t q[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   pat    = 0;

    // Classifier models, selected per test
    logic [2:0] cls;
    always_comb begin
        cls = 3'd0;
        case (pat)
            1: cls = (bus.cand_out >= 10'd37 && (bus.cand_out % 10'd3) == 10'd1)
                     ? 3'd5 : 3'(bus.cand_out % 10'd5);
            2: cls = (bus.cand_out >= 10'd5 && bus.cand_out <= 10'd304) ? 3'd2 : 3'd3;
            3: cls = 3'(bus.cand_out % 10'd7);
            4: cls = 3'd4;
            5: cls = (bus.cand_out == 10'd2 || bus.cand_out == 10'd9 ||
                      bus.cand_out == 10'd15) ? 3'd1 : 3'd0;
            default: cls = 3'd0;
        endcase
    end
    assign bus.cls_in = cls;

    task automatic chk(input string nm, input longint act, input longint exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle",  ($time - e.t_edge + 5) / 10, e.cyc);
                chk("found",       bus.found,       e.found);
                chk("match_vec",   bus.match_vec,   e.vec);
                chk("match_count", bus.match_count, e.cnt);
                chk("aborted",     bus.aborted,     e.ab);
            end
        end
    end

    function automatic exp_t mk(int c, logic f, logic [9:0] v, logic [10:0] n, logic a);
        exp_t e;
        e.t_edge = 0;
        e.cyc    = c;
        e.found  = f;
        e.vec    = v;
        e.cnt    = n;
        e.ab     = a;
        return e;
    endfunction

    // Leaves the caller at the falling edge in cycle 1 of the new search
    task automatic issue(input logic m, input logic [2:0] t, input int p,
                         input bit push, input exp_t e, input logic ab_too);
        @(negedge clk);
        pat        = p;
        bus.mode   = m;
        bus.target = t;
        bus.start  = 1'b1;
        bus.abort  = ab_too;
        if (push) begin
            e.t_edge = $time + 5;
            q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            ntests++;
            nfail++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", budget);
        end
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"},  bus.busy,        0);
        chk({tag, "_done"},  bus.done,        0);
        chk({tag, "_cand"},  bus.cand_out,    0);
        chk({tag, "_found"}, bus.found,       0);
        chk({tag, "_vec"},   bus.match_vec,   0);
        chk({tag, "_cnt"},   bus.match_count, 0);
        chk({tag, "_ab"},    bus.aborted,     0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.target = 3'd0;
        bus.abort  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_cleared("reset");

        // Find-first, first match at 37 -> done in cycle 39
        issue(1'b0, 3'd5, 1, 1'b1, mk(39, 1'b1, 10'd37, 11'd1, 1'b0), 1'b0);
        chk("ff_busy_c1", bus.busy, 1);
        chk("ff_cand_c1", bus.cand_out, 0);
        wait_done(1100);
        chk("ff_cand_hold", bus.cand_out, 37);

        // Count-all, matches 5..304; a start mid-scan must be ignored
        issue(1'b1, 3'd2, 2, 1'b1, mk(1025, 1'b1, 10'd5, 11'd300, 1'b0), 1'b0);
        repeat (3) @(negedge clk);
        bus.start  = 1'b1;
        bus.mode   = 1'b0;
        bus.target = 3'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(1100);
        repeat (3) @(negedge clk);
        chk("hold_cnt",  bus.match_count, 300);
        chk("hold_vec",  bus.match_vec, 5);
        chk("hold_cand", bus.cand_out, 1023);

        // Find-first, target never produced
        issue(1'b0, 3'd7, 3, 1'b1, mk(1025, 1'b0, 10'd0, 11'd0, 1'b0), 1'b0);
        wait_done(1100);

        // Count-all, every vector matches
        issue(1'b1, 3'd4, 4, 1'b1, mk(1025, 1'b1, 10'd0, 11'd1024, 1'b0), 1'b0);
        wait_done(1100);

        // Abort in IDLE has no effect
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", bus.busy, 0);
        chk("idle_abort_ab",   bus.aborted, 0);
        chk("idle_abort_cnt",  bus.match_count, 1024);

        // Abort in cycle 11 of a count-all scan, hits at 2 and 9
        issue(1'b1, 3'd1, 5, 1'b1, mk(12, 1'b1, 10'd2, 11'd2, 1'b1), 1'b0);
        repeat (10) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_done(1100);

        // Reset in cycle 500 discards the search
        issue(1'b1, 3'd4, 4, 1'b0, mk(0, 1'b0, 10'd0, 11'd0, 1'b0), 1'b0);
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_cleared("midrst");
        repeat (5) @(negedge clk);
        issue(1'b0, 3'd4, 4, 1'b1, mk(2, 1'b1, 10'd0, 11'd1, 1'b0), 1'b0);
        chk("rst2_cand_c1", bus.cand_out, 0);
        chk("rst2_cnt_c1",  bus.match_count, 0);
        wait_done(20);

        // Start and abort together in IDLE: start wins
        issue(1'b0, 3'd4, 4, 1'b1, mk(2, 1'b1, 10'd0, 11'd1, 1'b0), 1'b1);
        wait_done(20);

        repeat (2) @(negedge clk);
        chk("pending_expectations", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dtc_preimage_search.md
DTC_PREIMAGE_SEARCH -- requirements
Module: dtc_preimage_search

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL: start  input  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-004 SHALL: mode  input  1  0 = find-first, 1 = count-all; captured with start.
REQ-005 SHALL: target  input  3  class code sought; captured with start.
REQ-006 SHALL: abort  input  1  terminates an active search.
REQ-007 SHALL: cand_out  output  10  candidate feature vector driven to the classifier inp port.
REQ-008 SHALL: cls_in  input  3  class returned by the combinational classifier for cand_out, valid in the same cycle.
REQ-009 SHALL: busy  output  1  high in SCAN.
REQ-010 SHALL: done  output  1  one-cycle pulse at search end.
REQ-011 SHALL: found  output  1  at least one match seen in the last search.
REQ-012 SHALL: match_vec  output  10  lowest candidate that matched in the last search.
REQ-013 SHALL: match_count  output  11  number of matching candidates, range 0..1024.
REQ-014 SHALL: aborted  output  1  last search ended by abort.

Function
REQ-015 SHALL: FSM states IDLE, SCAN, DONE; cand_out, target_q, mode_q registered.
REQ-016 SHALL: IDLE with start=1 -> SCAN; on that edge cand_out<=0, match_count<=0, found<=0, match_vec<=0, aborted<=0, target_q<=target, mode_q<=mode.
REQ-017 SHALL: start while in SCAN or DONE is ignored; no parameter changes.
REQ-018 SHALL: in SCAN, each edge evaluates hit = (cls_in == target_q) for current cand_out.
REQ-019 SHALL: on a hit, match_count increments by 1; if found=0, match_vec<=cand_out and found<=1.
REQ-020 SHALL: find-first mode: first hit -> DONE on the same edge; cand_out not advanced.
REQ-021 SHALL: count-all mode, and find-first with no hit: cand_out increments each edge; after evaluating cand_out=1023 -> DONE; cand_out never wraps to 0 inside a search.
REQ-022 SHALL: match_count reaches 1024 without overflow when every candidate matches.
REQ-023 SHALL: DONE lasts exactly one cycle with done=1, then -> IDLE.
REQ-024 SHALL: latency from start-accept edge: cand k in cycle k+1; find-first hit at k -> done in cycle k+2; full scan -> done in cycle 1025.
REQ-025 SHALL: abort in SCAN -> DONE, aborted<=1, no hit recorded on that edge; results reflect candidates evaluated before it.
REQ-026 SHALL: abort outside SCAN is ignored; abort with start in IDLE -> start wins.
REQ-027 SHALL: found, match_vec, match_count, aborted hold from DONE until the next accepted start.
REQ-028 SHALL: cand_out holds its last value in IDLE and DONE.

Reset
REQ-029 SHALL: rst=1 at any edge forces IDLE; cand_out=0, busy=0, done=0, found=0, match_vec=0, match_count=0, aborted=0, target_q=0, mode_q=0.
REQ-030 SHALL: rst mid-search discards the search; no done pulse is produced.
REQ-031 SHALL: rst has priority over start and abort.

Verification
REQ-032 SHALL: find-first, target=3'b101, model first matches at cand 37 -> done in cycle 39, found=1, match_vec=37, match_count=1.
REQ-033 SHALL: count-all, model matches 300 vectors, lowest 5 -> done in cycle 1025, match_count=300, match_vec=5, found=1.
REQ-034 SHALL: find-first, target never produced -> done in cycle 1025, found=0, match_count=0, match_vec=0.
REQ-035 SHALL: count-all, all vectors match -> match_count=1024, match_vec=0.
REQ-036 SHALL: abort in cycle 11 of a count-all scan, hits at 2 and 9 -> done in cycle 12, aborted=1, match_count=2, match_vec=2.
REQ-037 SHALL: rst in cycle 500 of a scan, then start -> no done from the first search; the second search starts at cand 0 with cleared results.
